// File: rtl/c432_irq_sequencer.sv
// Sequencer in front of the external c432 interrupt resolver: captures requests, freezes a snapshot, samples the result and grants with valid/ack.
// Optional macro IRQ_TIMEOUT_EN adds an ACK_TIMEOUT abort from GRANT and drives the sticky irq_tmo flag.
module c432_irq_sequencer #(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [26:0] irq_req,
  input  logic [8:0]  cfg_en,
  output logic [8:0]  pri_e,
  output logic [8:0]  pri_a,
  output logic [8:0]  pri_b,
  output logic [8:0]  pri_c,
  input  logic        pri_pa,
  input  logic        pri_pb,
  input  logic        pri_pc,
  input  logic [3:0]  pri_chan,
  output logic        irq_valid,
  output logic [1:0]  irq_grp,
  output logic [3:0]  irq_chan,
  input  logic        irq_ack,
  output logic        irq_err,
  output logic        irq_tmo
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
    $error("SETTLE_CYC must be 1..15");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_GRANT,
    S_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic [26:0] pend_q, pend_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [8:0]  pri_e_q, pri_e_d;
  logic [8:0]  pri_a_q, pri_a_d;
  logic [8:0]  pri_b_q, pri_b_d;
  logic [8:0]  pri_c_q, pri_c_d;
  logic        valid_q, valid_d;
  logic [1:0]  grp_q, grp_d;
  logic [3:0]  chan_q, chan_d;
  logic        err_q, err_d;
  logic        tmo_q, tmo_d;
  logic [26:0] clr_mask;
  logic [4:0]  grant_idx;
`ifdef IRQ_TIMEOUT_EN
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Priority index 0 (A ch0) maps to bit 26; index grows toward bit 0.
  assign grant_idx = 5'(grp_q) * 5'd9 + {1'b0, chan_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pri_e_d  = pri_e_q;
    pri_a_d  = pri_a_q;
    pri_b_d  = pri_b_q;
    pri_c_d  = pri_c_q;
    valid_d  = valid_q;
    grp_d    = grp_q;
    chan_d   = chan_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    clr_mask = '0;
`ifdef IRQ_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (|(pend_q & {3{cfg_en}})) begin
          pri_a_d = pend_q[26:18];
          pri_b_d = pend_q[17:9];
          pri_c_d = pend_q[8:0];
          pri_e_d = cfg_en;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYC - 1)) begin
          if ((pri_pa || pri_pb || pri_pc) && (pri_chan <= 4'd8)) begin
            grp_d   = pri_pa ? 2'd0 : (pri_pb ? 2'd1 : 2'd2);
            chan_d  = pri_chan;
            valid_d = 1'b1;
            state_d = S_GRANT;
`ifdef IRQ_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            err_d   = 1'b1;
            pri_a_d = '0;
            pri_b_d = '0;
            pri_c_d = '0;
            pri_e_d = '0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GRANT: begin
        if (irq_ack) begin
          valid_d = 1'b0;
          state_d = S_CLEAR;
        end
`ifdef IRQ_TIMEOUT_EN
        // The granted bit is not cleared on abort, so it is re-arbitrated.
        else if (tmo_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          valid_d = 1'b0;
          tmo_d   = 1'b1;
          pri_a_d = '0;
          pri_b_d = '0;
          pri_c_d = '0;
          pri_e_d = '0;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      S_CLEAR: begin
        clr_mask = 27'd1 << (5'd26 - grant_idx);
        pri_a_d  = '0;
        pri_b_d  = '0;
        pri_c_d  = '0;
        pri_e_d  = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request arriving in the CLEAR cycle keeps its bit pending.
    pend_d = (pend_q & ~clr_mask) | irq_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
      pri_e_q <= '0;
      pri_a_q <= '0;
      pri_b_q <= '0;
      pri_c_q <= '0;
      valid_q <= 1'b0;
      grp_q   <= '0;
      chan_q  <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
`ifdef IRQ_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      pri_e_q <= pri_e_d;
      pri_a_q <= pri_a_d;
      pri_b_q <= pri_b_d;
      pri_c_q <= pri_c_d;
      valid_q <= valid_d;
      grp_q   <= grp_d;
      chan_q  <= chan_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
`ifdef IRQ_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

  assign pri_e     = pri_e_q;
  assign pri_a     = pri_a_q;
  assign pri_b     = pri_b_q;
  assign pri_c     = pri_c_q;
  assign irq_valid = valid_q;
  assign irq_grp   = grp_q;
  assign irq_chan  = chan_q;
  assign irq_err   = err_q;
  assign irq_tmo   = tmo_q;

endmodule

// File: tb/tb_c432_irq_sequencer.sv
// Bench for c432_irq_sequencer: behavioural c432 resolver plus a pending-set model of expected grants.
module tb_c432_irq_sequencer;
  localparam int S = 2;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [26:0] irq_req;
  logic [8:0]  cfg_en;
  logic [8:0]  pri_e, pri_a, pri_b, pri_c;
  logic        pri_pa, pri_pb, pri_pc;
  logic [3:0]  pri_chan;
  logic        irq_valid;
  logic [1:0]  irq_grp;
  logic [3:0]  irq_chan;
  logic        irq_ack;
  logic        irq_err;
  logic        irq_tmo;

  int total = 0;
  int bad   = 0;
  int rmode = 0;  // 0 normal resolver, 1 no group flag, 2 channel 4'hF

  c432_irq_sequencer #(.SETTLE_CYC(S), .ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .cfg_en(cfg_en),
    .pri_e(pri_e), .pri_a(pri_a), .pri_b(pri_b), .pri_c(pri_c),
    .pri_pa(pri_pa), .pri_pb(pri_pb), .pri_pc(pri_pc), .pri_chan(pri_chan),
    .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_chan(irq_chan),
    .irq_ack(irq_ack), .irq_err(irq_err), .irq_tmo(irq_tmo)
  );

  always #5 clk = ~clk;

  // Highest set bit = highest priority (A before B before C, channel 0 first).
  function automatic int top_bit(input logic [26:0] v);
    for (int i = 26; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  always_comb begin
    automatic int w = top_bit({pri_a, pri_b, pri_c} & {3{pri_e}});
    pri_pa = 1'b0; pri_pb = 1'b0; pri_pc = 1'b0; pri_chan = 4'd0;
    if (w >= 0) begin
      pri_pa   = ((26 - w) / 9) == 0;
      pri_pb   = ((26 - w) / 9) == 1;
      pri_pc   = ((26 - w) / 9) == 2;
      pri_chan = 4'((26 - w) % 9);
    end
    if (rmode == 1) begin
      pri_pa = 1'b0; pri_pb = 1'b0; pri_pc = 1'b0;
    end else if (rmode == 2) begin
      pri_chan = 4'hF;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget) begin
      step(); n++;
      if (irq_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse(input logic [26:0] r);
    irq_req = r; step(); irq_req = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_req = '0; cfg_en = 9'h1FF; irq_ack = 1'b0; rmode = 0;
    repeat (3) step();
    total++;
    if ({irq_valid, irq_grp, irq_chan, irq_err, irq_tmo} !== 9'd0) begin
      bad++; $display("FAIL reset_outs: got %h want 0", {irq_valid, irq_grp, irq_chan, irq_err, irq_tmo});
    end
    total++;
    if ({pri_e, pri_a, pri_b, pri_c} !== 36'd0) begin
      bad++; $display("FAIL reset_pri: got %h want 0", {pri_e, pri_a, pri_b, pri_c});
    end
    rst_n = 1'b1; step();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if (irq_valid !== 1'b0 || {pri_e, pri_a, pri_b, pri_c} !== 36'd0) begin
        bad++; $display("FAIL idle cyc %0d: valid=%b pri=%h want 0", i, irq_valid, {pri_e, pri_a, pri_b, pri_c});
      end
    end
  endtask

  task automatic test_single();
    int k; int n; bit ok;
    irq_req = 27'd1 << 26; k = 0;
    do begin
      step(); k++;
      irq_req = '0;
    end while (!irq_valid && k < 20);
    total++;
    if (k !== S + 2) begin bad++; $display("FAIL single_latency: got %0d want %0d", k, S + 2); end
    total++;
    if (irq_grp !== 2'd0 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL single_grant: got grp=%0d chan=%0d want 0/0", irq_grp, irq_chan);
    end
    do_ack();
    total++;
    if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_ack_drop: got valid=%b want 0", irq_valid); end
    wait_valid(30, n, ok);
    total++;
    if (ok) begin bad++; $display("FAIL single_cleared: got regrant grp=%0d chan=%0d want none", irq_grp, irq_chan); end
  endtask

  task automatic test_group_prio();
    int n; bit ok;
    pulse((27'd1 << 17) | (27'd1 << 8));
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd1 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL prio_first: got ok=%0d grp=%0d chan=%0d want 1/1/0", ok, irq_grp, irq_chan);
    end
    do_ack();
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd2 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL prio_second: got ok=%0d grp=%0d chan=%0d want 1/2/0", ok, irq_grp, irq_chan);
    end
    do_ack();
    wait_valid(30, n, ok);
    total++;
    if (ok) begin bad++; $display("FAIL prio_drained: got extra grant grp=%0d chan=%0d", irq_grp, irq_chan); end
  endtask

  task automatic test_mask();
    int n; bit ok; int seen;
    cfg_en = 9'h000;
    pulse(27'd1 << 26);
    seen = 0;
    for (int i = 0; i < 100; i++) begin step(); if (irq_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mask_blocked: got %0d valid cycles want 0", seen); end
    cfg_en = 9'h100;
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd0 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL mask_enable: got ok=%0d grp=%0d chan=%0d want 1/0/0", ok, irq_grp, irq_chan);
    end
    do_ack();
    cfg_en = 9'h1FF;
    wait_valid(30, n, ok);
    total++;
    if (ok) begin bad++; $display("FAIL mask_drained: got extra grant grp=%0d chan=%0d", irq_grp, irq_chan); end
  endtask

  task automatic test_illegal();
    int n; bit ok; int seen;
    rmode = 1;
    pulse(27'd1 << 20);
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (irq_valid) seen++; end
    total++;
    if (irq_err !== 1'b1 || seen != 0) begin
      bad++; $display("FAIL illegal_noflag: got err=%b valid_cycles=%0d want 1/0", irq_err, seen);
    end
    rmode = 2;
    seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (irq_valid) seen++; end
    total++;
    if (seen != 0) begin bad++; $display("FAIL illegal_chanF: got %0d valid cycles want 0", seen); end
    rmode = 0;
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd0 || irq_chan !== 4'd6) begin
      bad++; $display("FAIL illegal_recover: got ok=%0d grp=%0d chan=%0d want 1/0/6", ok, irq_grp, irq_chan);
    end
    total++;
    if (irq_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", irq_err); end
    do_ack();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    total++;
    if (irq_err !== 1'b0) begin bad++; $display("FAIL err_reset: got %b want 0", irq_err); end
  endtask

  task automatic test_random();
    logic [26:0] pend; logic [26:0] r; logic [26:0] inj; logic [8:0] en;
    int exp; int n; bit ok; int guard; int hold;
    pend = '0;
    for (int rnd = 0; rnd < 8; rnd++) begin
      r = 27'($urandom);
      if (r == '0) r = 27'd1;
      en = 9'($urandom_range(1, 511));
      cfg_en = en;
      pulse(r); pend |= r;
      for (int ph = 0; ph < 2; ph++) begin
        guard = 0;
        forever begin
          exp = top_bit(pend & {3{en}});
          if (exp < 0 || guard > 80) break;
          guard++;
          wait_valid(40, n, ok);
          total++;
          if (!ok || irq_grp !== 2'((26 - exp) / 9) || irq_chan !== 4'((26 - exp) % 9)) begin
            bad++;
            $display("FAIL rand_grant r%0d: got ok=%0d grp=%0d chan=%0d want grp=%0d chan=%0d",
                     rnd, ok, irq_grp, irq_chan, (26 - exp) / 9, (26 - exp) % 9);
            break;
          end
          hold = $urandom_range(0, 3);
          for (int h = 0; h < hold; h++) begin
            inj = ($urandom_range(0, 3) == 0) ? (27'd1 << $urandom_range(0, 26)) : 27'd0;
            irq_req = inj; pend |= inj;
            step(); irq_req = '0;
            total++;
            if (irq_valid !== 1'b1 || irq_grp !== 2'((26 - exp) / 9) || irq_chan !== 4'((26 - exp) % 9)) begin
              bad++; $display("FAIL rand_hold r%0d: got valid=%b grp=%0d chan=%0d", rnd, irq_valid, irq_grp, irq_chan);
            end
          end
          do_ack();
          pend &= ~(27'd1 << exp);
        end
        if (ph == 0) begin
          wait_valid(30, n, ok);
          total++;
          if (ok) begin bad++; $display("FAIL rand_masked r%0d: got grant grp=%0d chan=%0d want none", rnd, irq_grp, irq_chan); end
          en = 9'h1FF; cfg_en = en;
        end
      end
    end
    cfg_en = 9'h1FF;
  endtask

`ifdef IRQ_TIMEOUT_EN
  task automatic test_timeout();
    int n; bit ok; int hi; int drop;
    pulse(27'd1 << 26);
    wait_valid(40, n, ok);
    hi = 0;
    while (ok && irq_valid && hi < 40) begin step(); hi++; end
    total++;
    if (!ok || hi != T) begin bad++; $display("FAIL tmo_len: got ok=%0d cycles=%0d want %0d", ok, hi, T); end
    total++;
    if (irq_tmo !== 1'b1) begin bad++; $display("FAIL tmo_flag: got %b want 1", irq_tmo); end
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd0 || irq_chan !== 4'd0) begin
      bad++; $display("FAIL tmo_reissue: got ok=%0d grp=%0d chan=%0d want 1/0/0", ok, irq_grp, irq_chan);
    end
    drop = 0;
    for (int i = 0; i < T - 1; i++) begin step(); if (!irq_valid) drop++; end
    do_ack();
    total++;
    if (drop != 0 || irq_valid !== 1'b0) begin
      bad++; $display("FAIL tmo_ack_edge: got early_drops=%0d valid=%b want 0/0", drop, irq_valid);
    end
    wait_valid(30, n, ok);
    total++;
    if (ok) begin bad++; $display("FAIL tmo_ack_wins: got regrant want none"); end
  endtask
`else
  task automatic test_timeout();
    int n; bit ok; int drop;
    pulse(27'd1 << 26);
    wait_valid(40, n, ok);
    drop = 0;
    for (int i = 0; i < 300; i++) begin step(); if (!irq_valid || irq_tmo) drop++; end
    total++;
    if (!ok || drop != 0) begin bad++; $display("FAIL no_tmo_hold: got ok=%0d bad_cycles=%0d want 1/0", ok, drop); end
    do_ack();
  endtask
`endif

  task automatic test_reset_mid_grant();
    int n; bit ok;
    pulse(27'd1 << 5);
    wait_valid(40, n, ok);
    total++;
    if (!ok || irq_grp !== 2'd2 || irq_chan !== 4'd3) begin
      bad++; $display("FAIL rstmid_grant: got ok=%0d grp=%0d chan=%0d want 1/2/3", ok, irq_grp, irq_chan);
    end
    rst_n = 1'b0; #1;
    total++;
    if ({irq_valid, irq_grp, irq_chan, irq_err, irq_tmo} !== 9'd0 || {pri_e, pri_a, pri_b, pri_c} !== 36'd0) begin
      bad++; $display("FAIL rstmid_clear: got outs=%h pri=%h want 0",
                      {irq_valid, irq_grp, irq_chan, irq_err, irq_tmo}, {pri_e, pri_a, pri_b, pri_c});
    end
    step(); rst_n = 1'b1;
    wait_valid(30, n, ok);
    total++;
    if (ok) begin bad++; $display("FAIL rstmid_pending: got grant after reset want none"); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_group_prio();
    test_mask();
    test_illegal();
    test_random();
    test_timeout();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
